// File: rtl/rv32_pkg.sv
// RV32I decode types shared by the decode stage: opcodes, ALU ops, immediate formats,
// and the decoded-entry layout stored in the skid buffer.
package rv32_pkg;

    localparam int unsigned Xlen = 32;

    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    localparam logic [6:0] F7Base   = 7'b0000000;
    localparam logic [6:0] F7Alt    = 7'b0100000;
    localparam logic [6:0] F7MulDiv = 7'b0000001;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } imm_fmt_e;

    typedef struct packed {
        logic [Xlen-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        alu_op_e         alu_op;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            alu_src_imm;
        logic            alu_src_pc;
        logic            wb_sel_mem;
        logic            mul_div;
        logic            illegal;
    } dec_t;

    typedef struct packed {
        logic [Xlen-1:0] pc;
        dec_t            dec;
    } entry_t;

    // Shared by OP and OP-IMM when funct7 selects the base (non-alternate) operation.
    function automatic alu_op_e alu_op_base(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'b000:  op = AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    function automatic logic [Xlen-1:0] imm_extend(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [Xlen-1:0] imm;
        case (fmt)
            ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
            ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            ImmU:    imm = {instr[31:12], 12'b0};
            ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Purely combinational RV32I(+optional M) instruction decoder: control bits, register
// indices, sign-extended immediate and illegal-instruction flag.
module rv32_decode_comb
    import rv32_pkg::*;
#(
    parameter int unsigned ENABLE_M = 0
) (
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     jump;
    logic     alu_src_imm;
    logic     alu_src_pc;
    logic     wb_sel_mem;
    logic     mul_div;
    logic     illegal;
    alu_op_e  alu_op;
    imm_fmt_e imm_fmt;

    always_comb begin
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        alu_src_imm = 1'b0;
        alu_src_pc  = 1'b0;
        wb_sel_mem  = 1'b0;
        mul_div     = 1'b0;
        illegal     = 1'b0;
        alu_op      = AluAdd;
        imm_fmt     = ImmNone;

        unique case (opcode)
            OpcLui: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                alu_op      = AluPassB;
                imm_fmt     = ImmU;
            end
            OpcAuipc: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                alu_src_pc  = 1'b1;
                imm_fmt     = ImmU;
            end
            OpcJal: begin
                jump        = 1'b1;
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                alu_src_pc  = 1'b1;
                imm_fmt     = ImmJ;
            end
            OpcJalr: begin
                jump        = 1'b1;
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                imm_fmt     = ImmI;
                illegal     = (funct3 != 3'b000);
            end
            OpcBranch: begin
                branch  = 1'b1;
                alu_op  = AluSub;
                imm_fmt = ImmB;
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OpcLoad: begin
                mem_read    = 1'b1;
                wb_sel_mem  = 1'b1;
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                imm_fmt     = ImmI;
                illegal     = (funct3 == 3'b011) || (funct3 > 3'b101);
            end
            OpcStore: begin
                mem_write   = 1'b1;
                alu_src_imm = 1'b1;
                imm_fmt     = ImmS;
                illegal     = (funct3 > 3'b010);
            end
            OpcOpImm: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                imm_fmt     = ImmI;
                alu_op      = alu_op_base(funct3);
                // Only the shift-immediates constrain funct7 (it overlays imm[11:5]).
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != F7Base);
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7Alt) begin
                        alu_op = AluSra;
                    end else begin
                        illegal = (funct7 != F7Base);
                    end
                end
            end
            OpcOp: begin
                reg_write = 1'b1;
                case (funct7)
                    F7Base: alu_op = alu_op_base(funct3);
                    F7Alt: begin
                        if (funct3 == 3'b000) begin
                            alu_op = AluSub;
                        end else if (funct3 == 3'b101) begin
                            alu_op = AluSra;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    F7MulDiv: begin
                        if (ENABLE_M != 0) begin
                            mul_div = 1'b1;
                            alu_op  = alu_op_e'({1'b0, funct3});
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OpcMiscMem: illegal = (funct3 != 3'b000);
            OpcSystem:  illegal = 1'b1;
            default:    illegal = 1'b1;
        endcase
    end

    // An illegal entry still travels downstream, but must not cause any side effect.
    always_comb begin
        dec_o             = '0;
        dec_o.imm         = imm_extend(instr_i, imm_fmt);
        dec_o.rs1         = instr_i[19:15];
        dec_o.rs2         = instr_i[24:20];
        dec_o.funct3      = funct3;
        dec_o.illegal     = illegal;
        dec_o.alu_op      = illegal ? AluAdd : alu_op;
        dec_o.reg_write   = reg_write & ~illegal;
        dec_o.mem_read    = mem_read & ~illegal;
        dec_o.mem_write   = mem_write & ~illegal;
        dec_o.branch      = branch & ~illegal;
        dec_o.jump        = jump & ~illegal;
        dec_o.alu_src_imm = alu_src_imm & ~illegal;
        dec_o.alu_src_pc  = alu_src_pc & ~illegal;
        dec_o.wb_sel_mem  = wb_sel_mem & ~illegal;
        dec_o.mul_div     = mul_div & ~illegal;
        dec_o.rd          = dec_o.reg_write ? instr_i[11:7] : 5'd0;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes fetch input and holds up to two decoded entries
// in a skid FIFO so fetch keeps full throughput under execute back-pressure.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ENABLE_M = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [31:0]     in_instr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [4:0]      out_rd_o,
    output logic [4:0]      out_rs1_o,
    output logic [4:0]      out_rs2_o,
    output logic [XLEN-1:0] out_imm_o,
    output logic            out_reg_write_o,
    output logic            out_mem_read_o,
    output logic            out_mem_write_o,
    output logic            out_branch_o,
    output logic            out_jump_o,
    output logic            out_alu_src_imm_o,
    output logic            out_alu_src_pc_o,
    output logic            out_wb_sel_mem_o,
    output logic            out_mul_div_o,
    output logic            out_illegal_o,
    output logic [3:0]      out_alu_op_o,
    output logic [2:0]      out_funct3_o
);

    if (XLEN != 32) begin : g_xlen_check
        $error("decode_stage: XLEN must be 32");
    end

    dec_t in_dec;

    rv32_decode_comb #(
        .ENABLE_M(ENABLE_M)
    ) u_decode (
        .instr_i(in_instr_i),
        .dec_o  (in_dec)
    );

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;
    entry_t     mem_q [2];
    entry_t     mem_d [2];

    logic push;
    logic pop;

    assign push = in_valid_i && in_ready_q && !flush_i;
    assign pop  = (count_q != 2'd0) && out_ready_i && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q].pc  = in_pc_i;
                mem_d[wr_ptr_q].dec = in_dec;
                wr_ptr_d            = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        // Registered so out_ready never reaches in_ready combinationally.
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
        end
    end

    entry_t head;
    assign head = mem_q[rd_ptr_q];

    assign in_ready_o        = in_ready_q;
    assign out_valid_o       = (count_q != 2'd0);
    assign out_pc_o          = head.pc;
    assign out_rd_o          = head.dec.rd;
    assign out_rs1_o         = head.dec.rs1;
    assign out_rs2_o         = head.dec.rs2;
    assign out_imm_o         = head.dec.imm;
    assign out_reg_write_o   = head.dec.reg_write;
    assign out_mem_read_o    = head.dec.mem_read;
    assign out_mem_write_o   = head.dec.mem_write;
    assign out_branch_o      = head.dec.branch;
    assign out_jump_o        = head.dec.jump;
    assign out_alu_src_imm_o = head.dec.alu_src_imm;
    assign out_alu_src_pc_o  = head.dec.alu_src_pc;
    assign out_wb_sel_mem_o  = head.dec.wb_sel_mem;
    assign out_mul_div_o     = head.dec.mul_div;
    assign out_illegal_o     = head.dec.illegal;
    assign out_alu_op_o      = head.dec.alu_op;
    assign out_funct3_o      = head.dec.funct3;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (ENABLE_M=0/1) share stimulus and are checked
// every cycle against a queue-based handshake model and a field-level decode model.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        in_ready      [2];
    logic        out_valid     [2];
    logic [31:0] out_pc        [2];
    logic [4:0]  out_rd        [2];
    logic [4:0]  out_rs1       [2];
    logic [4:0]  out_rs2       [2];
    logic [31:0] out_imm       [2];
    logic        out_reg_write [2];
    logic        out_mem_read  [2];
    logic        out_mem_write [2];
    logic        out_branch    [2];
    logic        out_jump      [2];
    logic        out_src_imm   [2];
    logic        out_src_pc    [2];
    logic        out_wb_mem    [2];
    logic        out_mul_div   [2];
    logic        out_illegal   [2];
    logic [3:0]  out_alu_op    [2];
    logic [2:0]  out_funct3    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        decode_stage #(
            .XLEN    (32),
            .ENABLE_M(g)
        ) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .flush_i          (flush),
            .in_valid_i       (in_valid),
            .in_ready_o       (in_ready[g]),
            .in_pc_i          (in_pc),
            .in_instr_i       (in_instr),
            .out_valid_o      (out_valid[g]),
            .out_ready_i      (out_ready),
            .out_pc_o         (out_pc[g]),
            .out_rd_o         (out_rd[g]),
            .out_rs1_o        (out_rs1[g]),
            .out_rs2_o        (out_rs2[g]),
            .out_imm_o        (out_imm[g]),
            .out_reg_write_o  (out_reg_write[g]),
            .out_mem_read_o   (out_mem_read[g]),
            .out_mem_write_o  (out_mem_write[g]),
            .out_branch_o     (out_branch[g]),
            .out_jump_o       (out_jump[g]),
            .out_alu_src_imm_o(out_src_imm[g]),
            .out_alu_src_pc_o (out_src_pc[g]),
            .out_wb_sel_mem_o (out_wb_mem[g]),
            .out_mul_div_o    (out_mul_div[g]),
            .out_illegal_o    (out_illegal[g]),
            .out_alu_op_o     (out_alu_op[g]),
            .out_funct3_o     (out_funct3[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } txn_t;

    typedef struct packed {
        logic [31:0] imm;
        logic [14:0] regs;
        logic [16:0] ctrl;
    } ref_t;

    txn_t q[$];

    int         alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [6:0] op_tab  [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                                 7'h33, 7'h0f, 7'h73};

    // Reference decode straight from the RV32I encoding tables, using integer arithmetic.
    function automatic ref_t ref_decode(input logic [31:0] ins, input int en_m);
        ref_t r;
        int op, f3, f7, alu, imm, immi, imms, immb, immu, immj;
        bit rw, mr, mw, br, jp, asi, asp, wbm, md, ill;
        op = int'(ins & 32'h7f);
        f3 = int'((ins >> 12) & 7);
        f7 = int'(ins >> 25);
        immi = int'(ins >> 20);
        if (immi >= 2048) immi -= 4096;
        imms = int'(((ins >> 25) << 5) | ((ins >> 7) & 31));
        if (imms >= 2048) imms -= 4096;
        immb = int'((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11)
                    | (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1));
        if (immb >= 4096) immb -= 8192;
        immu = int'(ins & 32'hffff_f000);
        immj = int'((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12)
                    | (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1));
        if (immj >= (1 << 20)) immj -= (1 << 21);
        rw = 0; mr = 0; mw = 0; br = 0; jp = 0; asi = 0; asp = 0; wbm = 0; md = 0; ill = 0;
        alu = 0;
        imm = 0;
        case (op)
            32'h37: begin rw = 1; asi = 1; alu = 10; imm = immu; end
            32'h17: begin rw = 1; asi = 1; asp = 1; imm = immu; end
            32'h6f: begin jp = 1; rw = 1; asi = 1; asp = 1; imm = immj; end
            32'h67: begin jp = 1; rw = 1; asi = 1; imm = immi; ill = (f3 != 0); end
            32'h63: begin br = 1; alu = 1; imm = immb; ill = (f3 == 2 || f3 == 3); end
            32'h03: begin mr = 1; wbm = 1; rw = 1; asi = 1; imm = immi; ill = (f3 == 3 || f3 > 5); end
            32'h23: begin mw = 1; asi = 1; imm = imms; ill = (f3 > 2); end
            32'h13: begin
                rw = 1; asi = 1; imm = immi; alu = alu_tab[f3];
                if (f3 == 1) ill = (f7 != 0);
                if (f3 == 5) begin
                    if (f7 == 32) alu = 7;
                    else ill = (f7 != 0);
                end
            end
            32'h33: begin
                rw = 1;
                if (f7 == 0) alu = alu_tab[f3];
                else if (f7 == 32 && f3 == 0) alu = 1;
                else if (f7 == 32 && f3 == 5) alu = 7;
                else if (f7 == 1 && en_m != 0) begin md = 1; alu = f3; end
                else ill = 1;
            end
            32'h0f: ill = (f3 != 0);
            default: ill = 1;
        endcase
        if (ill) begin
            rw = 0; mr = 0; mw = 0; br = 0; jp = 0; asi = 0; asp = 0; wbm = 0; md = 0;
            alu = 0;
        end
        r.imm  = imm;
        r.regs = {(rw ? ins[11:7] : 5'd0), ins[19:15], ins[24:20]};
        r.ctrl = {rw, mr, mw, br, jp, asi, asp, wbm, md, ill, 4'(alu), 3'(f3)};
        return r;
    endfunction

    task automatic check_outputs();
        ref_t r;
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("in_ready[%0d]", g), in_ready[g], q.size() < 2);
            check_eq($sformatf("out_valid[%0d]", g), out_valid[g], q.size() > 0);
            if (q.size() > 0) begin
                r = ref_decode(q[0].instr, g);
                check_eq($sformatf("pc[%0d]", g), out_pc[g], q[0].pc);
                check_eq($sformatf("imm[%0d] instr=%h", g, q[0].instr), out_imm[g], r.imm);
                check_eq($sformatf("regs[%0d] instr=%h", g, q[0].instr),
                         {out_rd[g], out_rs1[g], out_rs2[g]}, r.regs);
                check_eq($sformatf("ctrl[%0d] instr=%h", g, q[0].instr),
                         {out_reg_write[g], out_mem_read[g], out_mem_write[g], out_branch[g],
                          out_jump[g], out_src_imm[g], out_src_pc[g], out_wb_mem[g],
                          out_mul_div[g], out_illegal[g], out_alu_op[g], out_funct3[g]},
                         r.ctrl);
            end
        end
    endtask

    // Drive one cycle at the negedge, update the model at the posedge, check at next negedge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic rdy, input logic fl);
        bit acc, pop;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = rdy;
        flush     = fl;
        acc = v && (q.size() < 2) && !fl;
        pop = (q.size() > 0) && rdy && !fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{pc: pc, instr: instr});
        end
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 11) w[6:0] = op_tab[k];
        case ($urandom_range(0, 3))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            2:       w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();
        check_eq("reset_pc", out_pc[0], 32'h0);
        check_eq("reset_imm", out_imm[0], 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs();

        // addi x1,x0,-5
        step(1'b1, 32'h100, 32'hffb00093, 1'b1, 1'b0);
        check_eq("addi_valid", out_valid[0], 1'b1);
        check_eq("addi_imm", out_imm[0], 32'hffff_fffb);
        check_eq("addi_rd", out_rd[0], 5'd1);
        check_eq("addi_alu", out_alu_op[0], 4'd0);
        check_eq("addi_rw_src", {out_reg_write[0], out_src_imm[0]}, 2'b11);

        // sub, sw, beq -8, jal +2048 back-to-back
        step(1'b1, 32'h104, 32'h402081b3, 1'b1, 1'b0);
        check_eq("sub_alu", out_alu_op[0], 4'd1);
        step(1'b1, 32'h108, 32'h0020a423, 1'b1, 1'b0);
        check_eq("sw_alu", out_alu_op[0], 4'd0);
        step(1'b1, 32'h10c, 32'hfe208ce3, 1'b1, 1'b0);
        check_eq("beq_alu", out_alu_op[0], 4'd1);
        check_eq("beq_imm", out_imm[0], 32'hffff_fff8);
        step(1'b1, 32'h110, 32'h001000ef, 1'b1, 1'b0);
        check_eq("jal_alu", out_alu_op[0], 4'd0);
        check_eq("jal_imm", out_imm[0], 32'h0000_0800);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: two accepted, third held off, then drain in order
        step(1'b1, 32'h200, 32'h00100093, 1'b0, 1'b0);
        step(1'b1, 32'h204, 32'h00200113, 1'b0, 1'b0);
        check_eq("bp_in_ready_low", in_ready[0], 1'b0);
        step(1'b1, 32'h208, 32'h00300193, 1'b0, 1'b0);
        check_eq("bp_head_held", out_pc[0], 32'h200);
        step(1'b1, 32'h208, 32'h00300193, 1'b1, 1'b0);
        step(1'b1, 32'h208, 32'h00300193, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // mul with and without the M extension
        step(1'b1, 32'h300, 32'h02208033, 1'b0, 1'b0);
        check_eq("mul_m0_illegal", out_illegal[0], 1'b1);
        check_eq("mul_m0_rw", out_reg_write[0], 1'b0);
        check_eq("mul_m1_md", out_mul_div[1], 1'b1);
        check_eq("mul_m1_alu", out_alu_op[1], 4'd0);
        check_eq("mul_m1_rw", out_reg_write[1], 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Full buffer + flush with a same-cycle input
        step(1'b1, 32'h400, 32'h00500293, 1'b0, 1'b0);
        step(1'b1, 32'h404, 32'h00600313, 1'b0, 1'b0);
        step(1'b1, 32'h408, 32'h00700393, 1'b1, 1'b1);
        check_eq("flush_valid", out_valid[0], 1'b0);
        check_eq("flush_ready", in_ready[0], 1'b1);
        repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset with two entries buffered
        step(1'b1, 32'h500, 32'h00800413, 1'b0, 1'b0);
        step(1'b1, 32'h504, 32'h00900493, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("arst_valid[%0d]", g), out_valid[g], 1'b0);
            check_eq($sformatf("arst_ready[%0d]", g), in_ready[g], 1'b1);
            check_eq($sformatf("arst_pc[%0d]", g), out_pc[g], 32'h0);
            check_eq($sformatf("arst_imm[%0d]", g), out_imm[g], 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic with back-pressure and occasional flush
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), ($urandom & 32'hffff_fffc), rand_instr(),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I instruction-decode pipeline stage sitting between fetch and execute. It accepts `{pc, instr}` through a valid/ready handshake and decodes the instruction into control bits, register indices and a sign-extended immediate. It buffers up to two decoded entries in a skid buffer so fetch can run at full throughput under execute back-pressure. It also adds illegal-instruction flagging, optional M-extension decode and a pipeline flush.

## Interface
- `XLEN`, 32: datapath width of `pc`/`imm`; legal values 32 only, with an elaboration error otherwise. The parameter is reserved for RV64.
- `ENABLE_M`, 0: 1 = decode OP funct7=0000001 as M-extension; 0 = treat it as illegal.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous drop of all buffered entries and of the same-cycle input.
- `in_valid`  in  1  fetch offers `in_pc`/`in_instr`.
- `in_ready`  out  1  stage can accept; registered.
- `in_pc`  in  XLEN  instruction address.
- `in_instr`  in  32  instruction word.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  execute consumes the head entry.
- `out_pc`  out  XLEN  address of the head entry.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register fields, with rd forced to 0 when `reg_write`=0.
- `out_imm`  out  XLEN  sign-extended immediate by format (I/S/B/U/J); 0 for R-type.
- `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_branch`, `out_jump`, `out_alu_src_imm`, `out_alu_src_pc`, `out_wb_sel_mem`, `out_mul_div`, `out_illegal`  out  1 each  decoded control bits.
- `out_alu_op`  out  4  ALU operation; for `mul_div`=1, bits [2:0] = funct3.
- `out_funct3`  out  3  raw funct3, used for branch condition and load/store size.

## Operation
- ALU op codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B; 11–15 are reserved and never emitted.
- Per-opcode decode:
  - LUI: PASS_B with `alu_src_imm`.
  - AUIPC: ADD with `alu_src_pc` and `alu_src_imm`.
  - JAL: `jump`, ADD with pc and imm, `reg_write`.
  - JALR: `jump`, ADD with imm.
  - BRANCH: `branch`, SUB.
  - LOAD: `mem_read`, `wb_sel_mem`, `reg_write`.
  - STORE: `mem_write`.
  - OP-IMM: SLLI/SRLI/SRAI check funct7.
  - OP: uses funct7 bit 5 for SUB/SRA.
  - FENCE: no-op with all control bits 0.
- Any other opcode, bad funct3/funct7 combination, or ECALL/EBREAK sets `illegal`=1 and forces `reg_write`, `mem_*`, `branch` and `jump` to 0. The entry is still passed downstream.
- The skid buffer is a 2-entry FIFO (`count` 0..2, 1-bit read/write pointers, wrap mod 2) holding decoded entries.
- Accept when `in_valid && in_ready && !flush`; pop when `out_valid && out_ready && !flush`.
- Simultaneous push and pop leaves `count` unchanged; a push while full cannot occur because `in_ready`=0.
- `in_ready` is registered, equal to `count_next < 2`.
- Flush forces `count` to 0 and `out_valid` to 0 on the next cycle, with pointers reset to 0. Both the input and the pop in the flush cycle are discarded.

## Timing
- Reset: `count`=0, pointers=0, `out_valid`=0, `in_ready`=1. All `out_*` data fields are 0. Reset mid-transfer drops the entries.
- Latency: an entry accepted at edge N has `out_valid`=1 from after edge N, so it is visible in cycle N+1.
- Throughput: 1 instruction/cycle while `out_ready`=1.
- With `out_ready` held 0, exactly 2 entries are accepted, then `in_ready` falls after the second accept.
- Output fields are stable while `out_valid && !out_ready`.
- The decode is combinational on the input side and its result is written into the buffer; there is no combinational path from `in_*` to `out_*` and none from `out_ready` to `in_ready`.

## Structure
- Shared package `rv32_pkg`: opcode constants, the ALU op enum above, and the immediate-format enum.
- Sub-module `rv32_decode_comb`: purely combinational `instr` to control/imm/illegal, parametrised by `ENABLE_M`. `decode_stage` holds only the FIFO and handshake.

## Test plan
- Reset release, then `addi x1,x0,-5` (0xFFB00093) with `out_ready`=1 → one cycle later `out_valid`=1, `reg_write`=1, `alu_src_imm`=1, `alu_op`=0, `imm`=0xFFFFFFFB, `rd`=1.
- `sub`, `sw`, `beq` (offset -8), `jal` (+2048) back-to-back → 4 consecutive `out_valid` cycles with alu_op 1/0/1/0, and `imm` 0xFFFFFFF8 for `beq` and 0x800 for `jal`.
- `out_ready`=0 while 3 instructions are offered → first 2 accepted, `in_ready`=0 from the cycle after the second accept. Raising `out_ready` drains them in order; the third is then accepted.
- `mul` (0x02208033): with `ENABLE_M`=0 → `illegal`=1 and `reg_write`=0; with `ENABLE_M`=1 → `mul_div`=1, `alu_op`=0, `reg_write`=1.
- Buffer full (count=2) plus `flush` together with `in_valid` → next cycle `out_valid`=0, `in_ready`=1, and no stale entry ever appears.
- Assert `rst_n`=0 with 2 entries buffered → outputs go to reset values immediately, without waiting for a clock edge.
